// File: rtl/mul16_share_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing controller and its arbiter.
// Pure declarations: no timing and no backpressure of its own.
package mul16_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int CORE_LAT = 17;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul16_share_ctrl_if.sv
// Client and core signals of the shared multiplier controller.
// slave = controller view, master = clients plus core driving the controller.
interface mul16_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_flat;
  logic [N_REQ*W-1:0] b_flat;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [2*W-1:0]     rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               mul_start;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic [2*W-1:0]     mul_y;
  logic               mul_done;

  modport slave (
    input  req, a_flat, b_flat, mul_y, mul_done,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_a, mul_b
  );

  modport master (
    output req, a_flat, b_flat, mul_y, mul_done,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul16_share_ctrl_rr_arb.sv
// Combinational round-robin picker: search starts just after last_owner and wraps.
// Zero latency; a requester that is not picked simply stays pending.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_owner,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDW-1:0]   win_id,
  output logic             win_vld
);
  int idx;

  always_comb begin
    win_oh  = '0;
    win_id  = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_owner) + i) % N_REQ;
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_id      = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/mul16_share_ctrl.sv
// Shares one sequential multiplier among N_REQ clients: grant, run core, respond (20 cycles/job, 2 on zero operand).
// Requests are never dropped by the controller; clients hold req until gnt while a job is in flight.
module mul16_share_ctrl
  import mul16_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mul16_share_ctrl_if.slave bus
);
  localparam int IDW = clog2(N_REQ);
  localparam int CW  = clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]   rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d, mul_start_q, mul_start_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [IDW-1:0]   owner_q, owner_d, last_owner_q, last_owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] win_oh;
  logic [IDW-1:0]   win_id;
  logic             win_vld;

  rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .win_oh     (win_oh),
    .win_id     (win_id),
    .win_vld    (win_vld)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    mul_start_d  = mul_start_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;
    tmo_d        = 1'b0;
    case (state_q)
      // RESP doubles as an arbitration slot so back-to-back jobs cost no idle cycle.
      ST_IDLE, ST_RESP: begin
        mul_start_d = 1'b0;
        state_d     = ST_IDLE;
        if (win_vld) begin
          state_d      = ST_GRANT;
          gnt_d        = win_oh;
          op_a_d       = bus.a_flat[int'(win_id)*W +: W];
          op_b_d       = bus.b_flat[int'(win_id)*W +: W];
          owner_d      = win_id;
          last_owner_d = win_id;
        end
      end
      ST_GRANT: begin
        if (op_a_q == '0 || op_b_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d     = ST_RUN;
          mul_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Registered compare keeps the counter off the abort path.
        cnt_d = cnt_q + 1'b1;
        tmo_d = (cnt_q == CW'(TIMEOUT - 1));
        if (bus.mul_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
          rsp_data_d  = bus.mul_y;
          rsp_err_d   = 1'b0;
          mul_start_d = 1'b0;
        end else if (tmo_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          mul_start_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      mul_start_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      owner_q      <= '0;
      last_owner_q <= IDW'(N_REQ - 1);
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      mul_start_q  <= mul_start_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = op_a_q;
  assign bus.mul_b     = op_b_q;
endmodule

// File: tb/tb_mul16_share_ctrl.sv
// Bench for mul16_share_ctrl: directed table, multi-cycle corner sequences and random jobs
// checked against a round-robin / arithmetic reference model; a simple 17-cycle core model answers mul_start.
module tb_mul16_share_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  localparam int TMO = 32;
  localparam int LAT_CORE = 17;

  logic clk, rst_n;
  logic core_en;
  int   core_cnt;
  int   cyc;
  int   start_cnt;
  int   n_chk, n_fail;
  int   last_m;

  mul16_share_ctrl_if #(.N_REQ(N), .W(W)) bus ();

  mul16_share_ctrl #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mul_start) start_cnt <= start_cnt + 1;
  end

  // Core: after start has been sampled high on 17 edges, pulse done with the product.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt     <= 0;
      bus.mul_done <= 1'b0;
      bus.mul_y    <= '0;
    end else begin
      bus.mul_done <= 1'b0;
      if (bus.mul_start) begin
        core_cnt <= core_cnt + 1;
        if (core_cnt == LAT_CORE - 1 && core_en) begin
          bus.mul_done <= 1'b1;
          bus.mul_y    <= {16'h0, bus.mul_a} * {16'h0, bus.mul_b};
        end
      end else begin
        core_cnt <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_for(input string nm, input bit want_rsp, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (want_rsp ? (bus.rsp_valid != '0) : (bus.gnt != '0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no %s within %0d cycles", nm, want_rsp ? "rsp_valid" : "gnt", bound);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int i = 1; i <= N; i++) begin
      if (m[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  // One job: raise mask, expect winner, drop req after gnt, then check the response.
  task automatic run_one(input string nm, input logic [N-1:0] mask, input int win,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    bit ok;
    int t_g, s0;
    @(negedge clk);
    bus.req = mask;
    s0 = start_cnt;
    wait_for({nm, "_gnt"}, 1'b0, 50, ok);
    if (ok) begin
      chk({nm, "_gnt"}, 96'(bus.gnt), 96'(4'b1 << win));
      t_g = cyc;
      last_m = win;
      bus.req = '0;
      @(posedge clk); #1;
      chk({nm, "_gnt_pulse"}, 96'(bus.gnt), 96'(0));
      ok = (bus.rsp_valid != '0);
      if (!ok) wait_for({nm, "_rsp"}, 1'b1, 60, ok);
      if (ok) begin
        chk({nm, "_rsp_valid"}, 96'(bus.rsp_valid), 96'(4'b1 << win));
        chk({nm, "_rsp_data"}, 96'(bus.rsp_data), 96'(exp_d));
        chk({nm, "_rsp_err"}, 96'(bus.rsp_err), 96'(exp_e));
        chk({nm, "_latency"}, 96'(cyc - t_g), 96'(exp_lat));
        chk({nm, "_start_in_resp"}, 96'(bus.mul_start), 96'(0));
        if (exp_lat == 1) chk({nm, "_no_start"}, 96'(start_cnt - s0), 96'(0));
        @(posedge clk); #1;
        chk({nm, "_rsp_pulse"}, 96'({bus.rsp_valid, bus.busy}), 96'(0));
      end
    end
    bus.req = '0;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [15:0]  a, b;
    int           win;
    logic [31:0]  data;
    int           lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int t_prev, t_g, rcnt;
    logic [15:0] av[N], bv[N];
    logic [N-1:0] m;
    int w;

    n_chk = 0; n_fail = 0; cyc = 0; start_cnt = 0;
    rst_n = 1'b0; core_en = 1'b1;
    bus.req = '0; bus.a_flat = '0; bus.b_flat = '0;
    last_m = N - 1;

    vecs[0] = '{4'b0010, 16'd300,   16'd200,   1, 32'd60000,     19};
    vecs[1] = '{4'b0001, 16'hFFFF,  16'hFFFF,  0, 32'hFFFE0001,  19};
    vecs[2] = '{4'b0100, 16'h0000,  16'h1234,  2, 32'h0,          1};
    vecs[3] = '{4'b1000, 16'h0007,  16'h0000,  3, 32'h0,          1};
    vecs[4] = '{4'b0110, 16'h1234,  16'h0010,  1, 32'h00012340,  19};

    #1;
    chk("reset_outputs", 96'({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy,
                              bus.mul_start, bus.mul_a, bus.mul_b}), 96'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table; operand lane = expected winner, other lanes filled with noise.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < N; k++) begin
        bus.a_flat[k*W +: W] = 16'($urandom_range(1, 65535));
        bus.b_flat[k*W +: W] = 16'($urandom_range(1, 65535));
      end
      bus.a_flat[vecs[v].win*W +: W] = vecs[v].a;
      bus.b_flat[vecs[v].win*W +: W] = vecs[v].b;
      run_one($sformatf("vec%0d", v), vecs[v].mask, vecs[v].win, vecs[v].data, 1'b0, vecs[v].lat);
    end

    // Round robin with all requests held: five grants 20 cycles apart.
    for (int k = 0; k < N; k++) begin
      bus.a_flat[k*W +: W] = 16'(k + 2);
      bus.b_flat[k*W +: W] = 16'(100 + k);
    end
    @(negedge clk);
    bus.req = 4'b1111;
    t_prev = 0;
    for (int g = 0; g < 5; g++) begin
      w = (last_m + 1) % N;
      wait_for($sformatf("rr%0d_gnt", g), 1'b0, 50, ok);
      if (!ok) break;
      chk($sformatf("rr%0d_gnt", g), 96'(bus.gnt), 96'(4'b1 << w));
      if (g > 0) chk($sformatf("rr%0d_spacing", g), 96'(cyc - t_prev), 96'(20));
      t_prev = cyc;
      last_m = w;
      if (g == 4) bus.req = '0;
      wait_for($sformatf("rr%0d_rsp", g), 1'b1, 50, ok);
      if (!ok) break;
      chk($sformatf("rr%0d_rsp_valid", g), 96'(bus.rsp_valid), 96'(4'b1 << w));
      chk($sformatf("rr%0d_rsp_data", g), 96'(bus.rsp_data), 96'((w + 2) * (100 + w)));
    end
    bus.req = '0;
    repeat (3) @(posedge clk);

    // Timeout: core never answers, then a normal job on the recovered controller.
    core_en = 1'b0;
    bus.a_flat[1*W +: W] = 16'd5;
    bus.b_flat[1*W +: W] = 16'd7;
    run_one("timeout", 4'b0010, rr_pick(4'b0010, last_m), 32'h0, 1'b1, TMO + 2);
    core_en = 1'b1;
    bus.a_flat[2*W +: W] = 16'd1000;
    bus.b_flat[2*W +: W] = 16'd1000;
    run_one("after_timeout", 4'b0100, rr_pick(4'b0100, last_m), 32'd1000000, 1'b0, 19);

    // Reset in the middle of RUN aborts silently and restarts arbitration at requester 0.
    bus.a_flat[3*W +: W] = 16'd3;
    bus.b_flat[3*W +: W] = 16'd4;
    @(negedge clk);
    bus.req = 4'b1000;
    wait_for("midrst_gnt", 1'b0, 50, ok);
    bus.req = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_running", 96'({bus.busy, bus.mul_start}), 96'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 96'({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy,
                               bus.mul_start, bus.mul_a, bus.mul_b}), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_m = N - 1;
    rcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid != '0) rcnt++;
    end
    chk("midrst_no_rsp", 96'(rcnt), 96'(0));
    bus.a_flat[0*W +: W] = 16'd9;
    bus.b_flat[0*W +: W] = 16'd11;
    run_one("post_reset", 4'b1001, 0, 32'd99, 1'b0, 19);

    // Random jobs against the reference model.
    for (int j = 0; j < 25; j++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        av[k] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        bv[k] = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
        bus.a_flat[k*W +: W] = av[k];
        bus.b_flat[k*W +: W] = bv[k];
      end
      w = rr_pick(m, last_m);
      run_one($sformatf("rand%0d", j), m, w, 32'(av[w]) * 32'(bv[w]), 1'b0,
              (av[w] == 0 || bv[w] == 0) ? 1 : 19);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures so far", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
